// File: rtl/fetch_pkg.sv
// Shared types and sizing for the instruction fetch stage.
// FETCH_PERF_EN (see fetch_cycle) adds performance counters.
package fetch_pkg;

   localparam int INST_W          = 16;
   localparam int ADDR_W          = 16;
   localparam int PC_STEP         = 2;
   localparam int FETCH_BUF_DEPTH = 2;

   typedef enum logic [1:0] {
      RST,
      FETCH,
      DRAIN
   } fetch_state_e;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry {pc, inst} FIFO between memory responses and decode.
// Clear wins over push and pop; pop and push may share a cycle.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic         clear,
   input  fetch_entry_t wdata,
   output fetch_entry_t head,
   output logic [1:0]   count
);

   fetch_entry_t ent_q [FETCH_BUF_DEPTH];
   fetch_entry_t ent_d [FETCH_BUF_DEPTH];
   logic [1:0]   cnt_q;
   logic [1:0]   cnt_d;

   always_comb begin
      ent_d = ent_q;
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else begin
         if (pop && cnt_q != 2'd0) begin
            ent_d[0] = ent_q[1];
            cnt_d    = cnt_q - 2'd1;
         end
         if (push && cnt_d < 2'(FETCH_BUF_DEPTH)) begin
            ent_d[cnt_d[0]] = wdata;
            cnt_d           = cnt_d + 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FETCH_BUF_DEPTH; i++) ent_q[i] <= '0;
         cnt_q <= '0;
      end else begin
         ent_q <= ent_d;
         cnt_q <= cnt_d;
      end
   end

   assign head  = ent_q[0];
   assign count = cnt_q;

endmodule

// File: rtl/fetch_cycle.sv
// Instruction fetch stage: PC, imem handshake, redirect and drain.
// Define FETCH_PERF_EN to add perf_fetched / perf_stall counters.
module fetch_cycle
   import fetch_pkg::*;
#(
   parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              stall,
   input  logic              branch_taken,
   input  logic [ADDR_W-1:0] branch_target,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] ir,
   output logic [ADDR_W-1:0] pc,
   output logic              ir_valid
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]       perf_fetched,
   output logic [15:0]       perf_stall
`endif
);

   fetch_state_e      state_q, state_d;
   logic [ADDR_W-1:0] fpc_q, fpc_d;
   logic [ADDR_W-1:0] tgt_q, tgt_d;
   logic [ADDR_W-1:0] br_pc;
   logic [1:0]        count;
   logic              pop, push, xfer;
   fetch_entry_t      head, wdata;

   assign br_pc    = branch_target & ~ADDR_W'(1);
   assign ir_valid = count != 2'd0;
   assign pop      = ir_valid && !stall;
   assign xfer     = imem_req && imem_ready;
   assign push     = (state_q == FETCH) && xfer && !branch_taken;
   assign wdata    = '{pc: fpc_q, inst: imem_rdata};

   // Only issue when the response is guaranteed a FIFO slot.
   always_comb begin
      imem_req = 1'b0;
      unique case (state_q)
         RST:     imem_req = 1'b0;
         FETCH:   imem_req = (count < 2'(FETCH_BUF_DEPTH)) || pop;
         DRAIN:   imem_req = 1'b1;
         default: imem_req = 1'b0;
      endcase
   end

   assign imem_addr = fpc_q;

   always_comb begin
      state_d = state_q;
      fpc_d   = fpc_q;
      tgt_d   = tgt_q;
      unique case (state_q)
         RST: begin
            state_d = FETCH;
            if (branch_taken) fpc_d = br_pc;
         end
         FETCH: begin
            if (branch_taken) begin
               if (imem_req && !imem_ready) begin
                  state_d = DRAIN;
                  tgt_d   = br_pc;
               end else begin
                  fpc_d = br_pc;
               end
            end else if (push) begin
               fpc_d = fpc_q + ADDR_W'(PC_STEP);
            end
         end
         DRAIN: begin
            if (branch_taken) tgt_d = br_pc;
            if (imem_ready) begin
               state_d = FETCH;
               fpc_d   = branch_taken ? br_pc : tgt_q;
            end
         end
         default: state_d = RST;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RST;
         fpc_q   <= RESET_PC;
         tgt_q   <= '0;
      end else begin
         state_q <= state_d;
         fpc_q   <= fpc_d;
         tgt_q   <= tgt_d;
      end
   end

   fetch_buffer u_buf (
      .clk   (clk),
      .rst_n (reset),
      .push  (push),
      .pop   (pop),
      .clear (branch_taken),
      .wdata (wdata),
      .head  (head),
      .count (count)
   );

   assign ir = head.inst;
   assign pc = head.pc;

`ifdef FETCH_PERF_EN
   logic [15:0] pf_q, pf_d;
   logic [15:0] ps_q, ps_d;

   always_comb begin
      pf_d = pf_q;
      ps_d = ps_q;
      if (push && pf_q != 16'hFFFF) pf_d = pf_q + 16'd1;
      if (ir_valid && stall && ps_q != 16'hFFFF) ps_d = ps_q + 16'd1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pf_q <= '0;
         ps_q <= '0;
      end else begin
         pf_q <= pf_d;
         ps_q <= ps_d;
      end
   end

   assign perf_fetched = pf_q;
   assign perf_stall   = ps_q;
`endif

endmodule

// File: doc/fetch_cycle.md
# fetch_cycle

Instruction fetch stage of the 16-bit pipeline; it produces the `ir`/`pc` pair that the decode stage consumes. Maintains the PC and issues requests to instruction memory over a ready-handshake. Buffers up to two fetched instructions so a decode stall never drops a memory response. Accepts branch redirects that flush buffered and in-flight fetches.

## Interface
- `RESET_PC`, 16'h0000, PC loaded on reset.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 clears all state.
- `stall`  in  1  decode cannot accept this cycle.
- `branch_taken`  in  1  redirect request, single-cycle pulse.
- `branch_target`  in  16  redirect PC; bit 0 ignored and forced 0.
- `imem_req`  out  1  memory request valid.
- `imem_addr`  out  16  request byte address.
- `imem_ready`  in  1  memory completes request this cycle.
- `imem_rdata`  in  16  instruction; valid when `imem_req && imem_ready`.
- `ir`  out  16  instruction to decode.
- `pc`  out  16  address of `ir`.
- `ir_valid`  out  1  `ir`/`pc` hold a real instruction.

## Operation
- Memory handshake: once `imem_req`=1, `imem_addr` holds stable until a cycle with `imem_ready`=1; the transfer completes on that edge. Only one request is outstanding at a time.
- Fetch PC advances by 2 per completed, non-squashed transfer. It wraps 16'hFFFE -> 16'h0000 silently.
- Buffer: 2-entry FIFO of {pc, inst}. The head drives `ir`/`pc`, and `ir_valid` = not empty.
  - Pop when `ir_valid && !stall`.
  - Push on completed, non-squashed transfer.
  - Push and pop in the same cycle are both allowed.
- Issue rule: `imem_req` asserts in FETCH only when (count − pop_this_cycle) < 2. A request held high is never withdrawn before `imem_ready`.
- States:
  - RST: entered on reset; no request. Goes to FETCH on the first edge with `reset`=1.
  - FETCH: normal issue.
  - DRAIN: a redirect arrived while a request was pending and not completing. `imem_req` stays high at the old address. The response is discarded on `imem_ready`, then the state goes to FETCH with fetch PC = saved target.
- Redirect (`branch_taken`=1), which has priority over push and pop:
  - FIFO is cleared at the edge.
  - Fetch PC becomes the target.
  - If no request is pending, or the pending request completes this same cycle (its data is dropped): stay in or go to FETCH, and the next request is to the target.
  - If a request is pending and not completing: go to DRAIN.
- Redirect in DRAIN: overwrite the saved target and remain in DRAIN.
- Reset mid-transaction: everything clears immediately and `imem_req` drops asynchronously. Memory must tolerate request withdrawal under reset.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `ir`=0, `pc`=0, `ir_valid`=0.
  - FIFO empty, state RST.
- First request: the cycle after the first edge with `reset` high.
- Latency: instruction is visible on `ir`/`ir_valid` in the cycle after its handshake edge.
- Throughput: 1 instruction/cycle with zero-wait memory (`imem_ready` tied 1) and `stall`=0.
- After a redirect edge, `ir_valid`=0 for at least 1 cycle. The first target instruction appears 1 cycle after its handshake.
- `ir`/`pc` hold stable while `stall`=1 and `ir_valid`=1.

## Configuration
- `FETCH_PERF_EN` defined: adds outputs `perf_fetched`[15:0] and `perf_stall`[15:0].
  - `perf_fetched` counts pushes.
  - `perf_stall` counts cycles with `ir_valid && stall`.
  - Both saturate at 16'hFFFF and reset to 0.
- Not defined: ports and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `fetch_pkg`:
  - State enum {RST, FETCH, DRAIN}.
  - `INST_W`=16, `ADDR_W`=16, `PC_STEP`=2, `FETCH_BUF_DEPTH`=2.
- Sub-module `fetch_buffer`: 2-entry FIFO with inputs push, pop, clear and outputs head, count. Clear has priority.

## Test plan
- Reset with `RESET_PC`=16'h0100, `imem_ready`=1, `stall`=0 -> requests at 0100, 0102, 0104 on consecutive cycles; `ir_valid` rises the cycle after the first handshake with `pc`=0100.
- `stall`=1 for 5 cycles, zero-wait memory -> FIFO fills to 2, `imem_req` drops, `ir`/`pc` frozen; on release, 2 buffered instructions drain in order with no gaps.
- `imem_ready` low for 3 cycles, then high -> `imem_addr` stable all 4 cycles; exactly one push.
- Redirect to 16'h0200 while a request to 0110 is pending with `imem_ready`=0 -> DRAIN; 0110 data never appears on `ir`; next request is to 0200.
- Redirect in the same cycle as `imem_ready`=1 -> that data is dropped; the next cycle requests the target; FIFO is empty.
- Fetch PC at 16'hFFFE -> next request is 16'h0000. With `FETCH_PERF_EN`, `perf_stall` saturates at FFFF under a long stall.
